// File: rtl/enemy_ai_ctrl.sv
// enemy_ai_ctrl
// Behaviour controller for the computer-driven enemy. On every decision tick
// it looks at the horizontal distance to the player, the player's attack and
// jump state and an 8-bit LFSR, and produces one registered command pulse
// set for the enemy motion datapath.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  decision strobe (tie high for per-clock decisions)
//   en                    AI enable; low on a tick forces IDLE
//   player_x, enemy_x     11-bit signed x positions
//   player_isJ            player airborne (rising edge can trigger a jump)
//   player_atk            player attacking (triggers a guard when in range)
//   enemy_isJ             enemy airborne (suppresses jumping)
//   right/left/jump/squat/defend/attack
//                         command pulses, high for the one cycle after the
//                         tick that decided them
//   state                 current behaviour state (debug)
//
// The command emitted on a tick belongs to the state being entered (or kept)
// on that tick, so the entry tick of a timed state already produces its first
// pulse. A timed state loaded with N-1 therefore yields exactly N pulses.
module enemy_ai_ctrl #(
    parameter int unsigned NEAR_DIST = 64,
    parameter int unsigned FAR_DIST  = 160,
    parameter int unsigned WIND_T    = 4,
    parameter int unsigned GUARD_T   = 8,
    parameter int unsigned COOL_T    = 16,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter bit          JUMP_RAND = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               en,
    input  logic signed [10:0] player_x,
    input  logic               player_isJ,
    input  logic               player_atk,
    input  logic signed [10:0] enemy_x,
    input  logic               enemy_isJ,
    output logic               right,
    output logic               left,
    output logic               jump,
    output logic               squat,
    output logic               defend,
    output logic               attack,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPROACH = 3'd1,
        S_WINDUP   = 3'd2,
        S_STRIKE   = 3'd3,
        S_GUARD    = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    localparam logic [11:0] NEAR_LIM   = 12'(NEAR_DIST);
    localparam logic [11:0] FAR_LIM    = 12'(FAR_DIST);
    localparam logic [7:0]  WIND_LOAD  = 8'(WIND_T - 1);
    localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_T - 1);
    localparam logic [7:0]  COOL_LOAD  = 8'(COOL_T - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [7:0]  lfsr_reg, lfsr_next;
    logic        pisj_reg, pisj_next;
    logic        right_reg, left_reg, jump_reg, squat_reg, defend_reg, attack_reg;
    logic        right_next, left_next, jump_next, squat_next, defend_next, attack_next;

    // Distance terms. Sign-extending to 12 bits keeps the difference exact.
    logic [11:0] dx;
    logic [11:0] adx;
    logic        dx_pos;
    logic        is_near;
    logic        is_far;
    logic        jump_ok;

    assign dx      = {enemy_x[10], enemy_x} - {player_x[10], player_x};
    assign adx     = dx[11] ? (~dx + 12'd1) : dx;
    assign dx_pos  = !dx[11] && (dx != 12'd0);   // enemy right of player: toward = left
    assign is_near = (adx <= NEAR_LIM);
    assign is_far  = (adx > FAR_LIM);
    // Rising edge is measured against the value captured at the previous tick.
    assign jump_ok = player_isJ && !pisj_reg && !enemy_isJ && (!JUMP_RAND || lfsr_reg[0]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= 8'd0;
            lfsr_reg   <= LFSR_SEED;
            pisj_reg   <= 1'b0;
            right_reg  <= 1'b0;
            left_reg   <= 1'b0;
            jump_reg   <= 1'b0;
            squat_reg  <= 1'b0;
            defend_reg <= 1'b0;
            attack_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            lfsr_reg   <= lfsr_next;
            pisj_reg   <= pisj_next;
            right_reg  <= right_next;
            left_reg   <= left_next;
            jump_reg   <= jump_next;
            squat_reg  <= squat_next;
            defend_reg <= defend_next;
            attack_reg <= attack_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        lfsr_next  = lfsr_reg;
        pisj_next  = pisj_reg;
        if (tick) begin
            // Taps 8,6,5,4 -> bits 7,5,4,3; runs every tick regardless of state.
            lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
            pisj_next = player_isJ;
            if (!en) begin
                state_next = S_IDLE;
                cnt_next   = 8'd0;
            end else begin
                case (state_reg)
                    S_IDLE: state_next = S_APPROACH;
                    S_APPROACH: begin
                        if (player_atk && !is_far) begin
                            state_next = S_GUARD;
                            cnt_next   = GUARD_LOAD;
                        end else if (is_near) begin
                            state_next = S_WINDUP;
                            cnt_next   = WIND_LOAD;
                        end
                    end
                    S_WINDUP: begin
                        if (cnt_reg == 8'd0) begin
                            state_next = S_STRIKE;
                        end else begin
                            cnt_next = cnt_reg - 8'd1;
                        end
                    end
                    S_STRIKE: begin
                        state_next = S_COOLDOWN;
                        cnt_next   = COOL_LOAD;
                    end
                    S_GUARD: begin
                        if (cnt_reg == 8'd0) begin
                            state_next = S_COOLDOWN;
                            cnt_next   = COOL_LOAD;
                        end else begin
                            cnt_next = cnt_reg - 8'd1;
                        end
                    end
                    S_COOLDOWN: begin
                        if (cnt_reg == 8'd0) begin
                            state_next = S_APPROACH;
                        end else begin
                            cnt_next = cnt_reg - 8'd1;
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        cnt_next   = 8'd0;
                    end
                endcase
            end
        end
    end

    // Output logic: commands decoded from the state being entered on this tick.
    always_comb begin
        right_next  = 1'b0;
        left_next   = 1'b0;
        jump_next   = 1'b0;
        squat_next  = 1'b0;
        defend_next = 1'b0;
        attack_next = 1'b0;
        if (tick && en) begin
            case (state_next)
                S_WINDUP: squat_next  = 1'b1;
                S_STRIKE: attack_next = 1'b1;
                S_GUARD:  defend_next = 1'b1;
                S_COOLDOWN: begin
                    right_next = dx_pos;
                    left_next  = !dx_pos;
                end
                S_APPROACH: begin
                    // Re-entry from IDLE or COOLDOWN is a silent tick.
                    if (state_reg == S_APPROACH) begin
                        if (is_far) begin
                            right_next = !dx_pos;
                            left_next  = dx_pos;
                        end
                        jump_next = jump_ok;
                    end
                end
                default: ;
            endcase
        end
    end

    assign right  = right_reg;
    assign left   = left_reg;
    assign jump   = jump_reg;
    assign squat  = squat_reg;
    assign defend = defend_reg;
    assign attack = attack_reg;
    assign state  = state_reg;

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// Testbench for enemy_ai_ctrl. Two instances share all inputs: one with the
// default random jump gate, one with JUMP_RAND=0. A plan-queue model predicts
// every cycle's outputs; directed scenarios add literal pulse-count checks.
module tb_enemy_ai_ctrl;

    localparam int NEAR = 64;
    localparam int FAR  = 160;
    localparam int WT   = 4;
    localparam int GT   = 8;
    localparam int CT   = 16;

    logic clk;
    logic rst_n;
    logic tick;
    logic en;
    logic signed [10:0] player_x;
    logic signed [10:0] enemy_x;
    logic player_isJ, player_atk, enemy_isJ;

    logic r_right, r_left, r_jump, r_squat, r_defend, r_attack;
    logic d_right, d_left, d_jump, d_squat, d_defend, d_attack;
    logic [2:0] r_state, d_state;
    logic [5:0] cmd_r, cmd_d;

    assign cmd_r = {r_right, r_left, r_jump, r_squat, r_defend, r_attack};
    assign cmd_d = {d_right, d_left, d_jump, d_squat, d_defend, d_attack};

    enemy_ai_ctrl dut_r (
        .clk(clk), .rst_n(rst_n), .tick(tick), .en(en),
        .player_x(player_x), .player_isJ(player_isJ), .player_atk(player_atk),
        .enemy_x(enemy_x), .enemy_isJ(enemy_isJ),
        .right(r_right), .left(r_left), .jump(r_jump), .squat(r_squat),
        .defend(r_defend), .attack(r_attack), .state(r_state)
    );

    enemy_ai_ctrl #(.JUMP_RAND(1'b0)) dut_d (
        .clk(clk), .rst_n(rst_n), .tick(tick), .en(en),
        .player_x(player_x), .player_isJ(player_isJ), .player_atk(player_atk),
        .enemy_x(enemy_x), .enemy_isJ(enemy_isJ),
        .right(d_right), .left(d_left), .jump(d_jump), .squat(d_squat),
        .defend(d_defend), .attack(d_attack), .state(d_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Plan tokens: what the enemy will do on each upcoming tick once committed.
    localparam int T_SQ = 1, T_ATK = 2, T_DEF = 3, T_AWAY = 4, T_REST = 5;

    int         plan[$];
    bit         m_active = 1'b0;
    bit         m_prev_isj = 1'b0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [5:0] exp_r = '0;
    logic [5:0] exp_d = '0;
    int         exp_state = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                plan.delete();
                m_active   = 1'b0;
                m_prev_isj = 1'b0;
                m_lfsr     = 8'hA5;
                exp_r      = '0;
                exp_d      = '0;
                exp_state  = 0;
            end else if (!tick) begin
                exp_r = '0;
                exp_d = '0;
            end else begin
                int dx, adx, tok;
                bit rt, lt, jr, jd, sq, df, at;
                dx  = int'(enemy_x) - int'(player_x);
                adx = (dx < 0) ? -dx : dx;
                {rt, lt, jr, jd, sq, df, at} = '0;
                if (!en) begin
                    plan.delete();
                    m_active  = 1'b0;
                    exp_state = 0;
                end else if (!m_active) begin
                    m_active  = 1'b1;
                    exp_state = 1;
                end else if (plan.size() != 0) begin
                    tok = plan.pop_front();
                    case (tok)
                        T_SQ:   begin sq = 1; exp_state = 2; end
                        T_ATK:  begin at = 1; exp_state = 3; end
                        T_DEF:  begin df = 1; exp_state = 4; end
                        T_AWAY: begin rt = (dx > 0); lt = !(dx > 0); exp_state = 5; end
                        default: exp_state = 1;
                    endcase
                end else if (player_atk && adx <= FAR) begin
                    df = 1;
                    exp_state = 4;
                    for (int i = 0; i < GT - 1; i++) plan.push_back(T_DEF);
                    for (int i = 0; i < CT; i++) plan.push_back(T_AWAY);
                    plan.push_back(T_REST);
                end else if (adx <= NEAR) begin
                    sq = 1;
                    exp_state = 2;
                    for (int i = 0; i < WT - 1; i++) plan.push_back(T_SQ);
                    plan.push_back(T_ATK);
                    for (int i = 0; i < CT; i++) plan.push_back(T_AWAY);
                    plan.push_back(T_REST);
                end else begin
                    exp_state = 1;
                    if (adx > FAR) begin
                        lt = (dx > 0);
                        rt = !(dx > 0);
                    end
                    if (player_isJ && !m_prev_isj && !enemy_isJ) begin
                        jd = 1;
                        jr = m_lfsr[0];
                    end
                end
                m_prev_isj = player_isJ;
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                exp_r = {rt, lt, jr, sq, df, at};
                exp_d = {rt, lt, jd, sq, df, at};
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmd_r", int'(cmd_r), int'(exp_r));
            check("cmd_d", int'(cmd_d), int'(exp_d));
            check("state_r", int'(r_state), exp_state);
            check("state_d", int'(d_state), exp_state);
        end
    end

    // ---------------- stimulus ----------------
    int tick_div = 1;
    int tick_phase = 0;
    int n_right, n_left, n_jump_r, n_jump_d, n_squat, n_defend, n_attack;

    task automatic clear_counts();
        n_right = 0; n_left = 0; n_jump_r = 0; n_jump_d = 0;
        n_squat = 0; n_defend = 0; n_attack = 0;
    endtask

    // One clock per iteration; outputs registered at that edge are tallied 2 ns later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            tick = (tick_div == 1) || (tick_phase == 0);
            tick_phase = (tick_phase + 1) % tick_div;
            @(posedge clk);
            #2;
            n_right  += int'(r_right);
            n_left   += int'(r_left);
            n_jump_r += int'(r_jump);
            n_jump_d += int'(d_jump);
            n_squat  += int'(r_squat);
            n_defend += int'(r_defend);
            n_attack += int'(r_attack);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; en = 1'b0;
        player_x = 11'sd100; enemy_x = 11'sd600;
        player_isJ = 1'b0; player_atk = 1'b0; enemy_isJ = 1'b0;
        clear_counts();
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", int'(r_state), 0);
        check("reset_cmd", int'(cmd_r), 0);
        rst_n = 1'b1;
        en = 1'b1;

        // Far approach: silent wake tick, then left every cycle.
        clear_counts();
        step(10);
        check("far_left", n_left, 9);
        check("far_right", n_right, 0);
        check("far_squat", n_squat, 0);
        check("far_state", int'(r_state), 1);

        // Attack sequence; player_atk during WINDUP must not divert it.
        enemy_x = 11'sd150;
        clear_counts();
        step(2);
        player_atk = 1'b1;
        step(20);
        player_atk = 1'b0;
        check("atk_squat", n_squat, 4);
        check("atk_attack", n_attack, 1);
        check("atk_right", n_right, 16);
        check("atk_defend", n_defend, 0);
        check("atk_state", int'(r_state), 1);

        // Guard preempts at adx=120.
        enemy_x = 11'sd220;
        player_atk = 1'b1;
        clear_counts();
        step(25);
        player_atk = 1'b0;
        check("grd_defend", n_defend, 8);
        check("grd_right", n_right, 16);
        check("grd_left", n_left, 0);
        check("grd_state", int'(r_state), 1);

        // Jump: single pulse on the rising edge, none while held, none if airborne.
        player_isJ = 1'b1;
        clear_counts();
        step(5);
        check("jmp_single", n_jump_d, 1);
        player_isJ = 1'b0;
        step(1);
        enemy_isJ = 1'b1;
        player_isJ = 1'b1;
        clear_counts();
        step(3);
        check("jmp_airborne_d", n_jump_d, 0);
        check("jmp_airborne_r", n_jump_r, 0);
        enemy_isJ = 1'b0;
        player_isJ = 1'b0;
        step(1);
        clear_counts();
        for (int i = 0; i < 12; i++) begin
            enemy_x = (i % 2 == 1) ? 11'sd600 : 11'sd220;
            player_isJ = 1'b0;
            step(1);
            player_isJ = 1'b1;
            step(1);
        end
        player_isJ = 1'b0;
        check("jmp_edges_d", n_jump_d, 12);
        step(1);

        // Tick every 4th cycle: timed lengths counted in ticks.
        tick_div = 4;
        tick_phase = 0;
        enemy_x = 11'sd150;
        clear_counts();
        step(88);
        check("tk_squat", n_squat, 4);
        check("tk_attack", n_attack, 1);
        check("tk_right", n_right, 16);
        check("tk_state", int'(r_state), 1);
        tick_div = 1;
        tick_phase = 0;

        // Enable dropped during GUARD.
        enemy_x = 11'sd220;
        player_atk = 1'b1;
        step(3);
        check("en_guard_state", int'(r_state), 4);
        en = 1'b0;
        step(1);
        check("en_off_state", int'(r_state), 0);
        check("en_off_cmd", int'(cmd_r), 0);
        en = 1'b1;
        player_atk = 1'b0;
        step(1);
        check("en_on_state", int'(r_state), 1);

        // Asynchronous reset during WINDUP.
        enemy_x = 11'sd150;
        step(1);
        check("rst_windup_state", int'(r_state), 2);
        rst_n = 1'b0;
        #1;
        check("rst_async_state", int'(r_state), 0);
        check("rst_async_cmd", int'(cmd_r), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // After reset the LFSR restarts from its seed; jump gating exposes it.
        enemy_x = 11'sd600;
        step(2);
        for (int i = 0; i < 8; i++) begin
            player_isJ = 1'b0;
            step(1);
            player_isJ = 1'b1;
            step(1);
        end
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
